// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - keypad row sync, frame assembly, frame debounce and key code output
// Optional KEYPAD_GHOST_REJECT_EN: multi-key frames are ignored instead of resolving to the lowest code.
module keypad_decoder #(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic [3:0] column,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASING} state_t;

    localparam logic [3:0] N = 4'(DEBOUNCE_FRAMES);

    logic [3:0] row_m_q, row_s_q, col_m_q, col_a_q;
    logic       in_frame_q, in_frame_d;
    logic [1:0] step_q, step_d;
    logic [1:0] hits_q, hits_d;
    logic [3:0] first_q, first_d;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cand_q, cand_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d, key_held_q, key_held_d;

    logic       frame_end, start, step_ok;
    logic [2:0] pop, sum;
    logic [1:0] low_row, col_idx, base_hits;
    logic [3:0] base_first;
    logic       resolved, none, match_cand, match_key;

    // Per-sample hit count and lowest hit row; hits saturate at 2 (MULTI).
    always_comb begin
        pop = {2'b0, row_s_q[0]} + {2'b0, row_s_q[1]} + {2'b0, row_s_q[2]} + {2'b0, row_s_q[3]};
        if (row_s_q[0])      low_row = 2'd0;
        else if (row_s_q[1]) low_row = 2'd1;
        else if (row_s_q[2]) low_row = 2'd2;
        else                 low_row = 2'd3;
        start      = (col_a_q == 4'b0001);
        step_ok    = in_frame_q && (col_a_q == (4'b0001 << step_q));
        base_hits  = start ? 2'd0 : hits_q;
        base_first = start ? 4'd0 : first_q;
        col_idx    = start ? 2'd0 : step_q;
        sum        = {1'b0, base_hits} + pop;
        in_frame_d = in_frame_q;
        step_d     = step_q;
        hits_d     = hits_q;
        first_d    = first_q;
        frame_end  = 1'b0;
        if (start || step_ok) begin
            hits_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
            first_d = (base_hits == 2'd0 && pop != 3'd0) ? {col_idx, low_row} : base_first;
            if (start) begin
                in_frame_d = 1'b1;
                step_d     = 2'd1;
            end else if (step_q == 2'd3) begin
                in_frame_d = 1'b0;
                frame_end  = 1'b1;
            end else begin
                step_d = step_q + 2'd1;
            end
        end else begin
            in_frame_d = 1'b0;
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    assign resolved = frame_end && (hits_d == 2'd1);
`else
    assign resolved = frame_end && (hits_d != 2'd0);
`endif
    assign none       = frame_end && (hits_d == 2'd0);
    assign match_cand = resolved && (first_d == cand_q);
    assign match_key  = resolved && (first_d == key_code_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (resolved || none) begin
            case (state_q)
                IDLE: begin
                    if (resolved) begin
                        cand_d = first_d;
                        cnt_d  = 4'd1;
                        if (N == 4'd1) begin
                            state_d     = PRESSED;
                            key_code_d  = first_d;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (match_cand) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == N) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                        end
                    end else if (resolved) begin
                        cand_d = first_d;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (!match_key) begin
                        cnt_d   = 4'd1;
                        state_d = (N == 4'd1) ? IDLE : RELEASING;
                    end
                end
                default: begin
                    if (match_key) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == N) begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                end
            endcase
        end
        key_held_d = (state_d == PRESSED) || (state_d == RELEASING);
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            row_m_q     <= 4'd0;
            row_s_q     <= 4'd0;
            col_m_q     <= 4'd0;
            col_a_q     <= 4'd0;
            in_frame_q  <= 1'b0;
            step_q      <= 2'd0;
            hits_q      <= 2'd0;
            first_q     <= 4'd0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            col_m_q     <= column;
            col_a_q     <= col_m_q;
            in_frame_q  <= in_frame_d;
            step_q      <= step_d;
            hits_q      <= hits_d;
            first_q     <= first_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Downstream consumer of the 4-column keypad scanner. Takes the one-hot `column` drive and the raw 4-bit row returns, then synchronizes the rows and aligns them to the column that produced them. Assembles complete scan frames, debounces across whole frames and emits a 4-bit key code with a one-cycle strobe plus a held level. It feeds the keypad command/entry logic.

## Interface
Parameters:
- `DEBOUNCE_FRAMES`, default 4: consecutive matching frames required to accept a press or a release. Legal range 1..15.

Ports:
- `clk_1`  input  1  scan clock, the same clock that drives the scanner.
- `rst`  input  1  reset, asynchronous and active-high.
- `column`  input  4  one-hot column drive from the scanner. Bit i drives column i.
- `row`  input  4  raw row returns, asynchronous to `clk_1`, active-high, bit j = row j.
- `key_code`  output  4  code of the accepted key, computed as col_idx*4 + row_idx. Holds its value after release.
- `key_valid`  output  1  one-cycle pulse when a press is accepted.
- `key_held`  output  1  high from press acceptance until release acceptance.

## Operation
- Row sync: `row` passes through a 2-flop synchronizer to give `row_s`.
- Alignment: `column` is delayed 2 registers to give `col_a`. `row_s` in a cycle is the response to `col_a` in that cycle.
- Frame assembly:
  - A valid frame is exactly `col_a` = 0001, 0010, 0100, 1000 on four consecutive cycles.
  - Any other `col_a` value, including 0000 or a multi-hot value, or any out-of-order step, aborts the frame. An aborted frame is discarded and causes no state or counter change.
  - The next frame starts at the next `col_a` = 0001.
- Frame result, taken from the 4 aligned samples:
  - NONE: all `row_s` are zero.
  - SINGLE(K): exactly one (column, row) hit. Row index is the set bit of `row_s`; column index is the set bit of `col_a`.
  - MULTI: more than one hit. Its handling is set in Configuration.
- FSM, evaluated only at the end of a valid frame. The counter `cnt` is 4 bits. N = `DEBOUNCE_FRAMES`.
  - IDLE:
    - SINGLE(K) sets cand=K and cnt=1, then goes to CONFIRM.
    - If N=1, it goes directly to PRESSED and accepts the press.
  - CONFIRM:
    - SINGLE(cand) increments cnt. When cnt reaches N, it goes to PRESSED, loads `key_code`=cand and pulses `key_valid`.
    - SINGLE(other) sets cand=other and cnt=1.
    - NONE sets cnt=0 and returns to IDLE.
  - PRESSED:
    - SINGLE(`key_code`) stays in PRESSED.
    - Any other result sets cnt=1 and goes to RELEASING. If N=1, it goes directly to IDLE.
  - RELEASING:
    - SINGLE(`key_code`) returns to PRESSED with no new `key_valid`.
    - Any other result increments cnt. When cnt reaches N, it goes to IDLE and `key_held` drops.
- `key_held` is 1 exactly while the FSM is in PRESSED or RELEASING.
- A different key pressed while one is held is not reported until the held key has released and the new key has debounced from IDLE.

## Timing
- Reset (asynchronous, takes effect immediately) clears the following:
  - FSM to IDLE, cnt=0, cand=0.
  - Sync and delay registers to 0, frame tracker cleared.
  - Outputs: `key_code`=0, `key_valid`=0, `key_held`=0.
- Reset mid-frame or mid-debounce discards all progress. The first frame after release of reset begins at the first `col_a`=0001.
- Frame-end decision: made on the edge that samples `col_a`=1000. `key_valid` and `key_held` change in the following cycle. `key_valid` is high for exactly 1 cycle.
- Press latency from a stable closure: at most 2 (sync) + 2 (align) + 4·(N+1) cycles.
- Release latency from a stable opening: at most the same figure.
- A closure that starts mid-frame and is not seen in all of that frame's samples does not count until the next full frame.

## Configuration
- `KEYPAD_GHOST_REJECT_EN`:
  - Defined: a MULTI frame is treated like an aborted frame (no state change).
  - Undefined: a MULTI frame resolves to SINGLE(lowest code among the hits).

## Test plan
- N=2, press key col 2 / row 1, held 20 frames. Expect `key_code`=9, one `key_valid` pulse at the end of the 2nd matching frame, `key_held`=1 until 2 NONE frames after release.
- Bounce: key 5 alternates each frame between present and absent for 6 frames. Expect no `key_valid` and `key_held`=0 throughout.
- Column held at 0000 for 10 cycles, then a normal scan with key 0 pressed. Expect no frames counted during the 0000 period, then `key_code`=0 accepted after N frames.
- Keys 3 and 12 pressed together. With the macro defined, expect no `key_valid`. Without it, expect `key_code`=3 accepted.
- `rst` pulsed while in RELEASING. Expect outputs 0 immediately, then re-acceptance of a still-pressed key after N fresh frames.
- Key 7 held, key 7 opens for 1 frame then closes, N=4. Expect `key_held` to stay 1 and no second `key_valid`.
